// File: rtl/dmem_arbiter_pkg.sv
// Shared types for the data-memory arbiter: FSM/owner encodings, bus widths
// and the read-return tag carried through the latency pipe.
package dmem_arbiter_pkg;

  localparam int DATA_W = 32;
  localparam int BE_W   = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_e;

  localparam logic [1:0] OWNER_NONE = 2'd0;
  localparam logic [1:0] OWNER_P0   = 2'd1;
  localparam logic [1:0] OWNER_P1   = 2'd2;

  typedef struct packed {
    logic valid;
    logic port;
  } rd_tag_t;

  function automatic logic [1:0] owner_of(input arb_state_e s);
    case (s)
      IDLE:    owner_of = OWNER_NONE;
      OWN0:    owner_of = OWNER_P0;
      OWN1:    owner_of = OWNER_P1;
      default: owner_of = OWNER_NONE;
    endcase
  endfunction

endpackage

// File: rtl/dmem_arbiter_rd_tag_pipe.sv
// Read-return tag pipe: DEPTH-deep {valid, port} shift register whose tap
// steers memory read data to the port that issued the read.
module dmem_arbiter_rd_tag_pipe
  import dmem_arbiter_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push_valid,
  input  logic              push_port,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1
);

  rd_tag_t pipe_r [DEPTH];
  rd_tag_t tap_s;

  // Shift every cycle; a new read loads stage 0 while older tags move on.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        pipe_r[i] <= '0;
      end
    end else begin
      pipe_r[0] <= '{valid: push_valid, port: push_port};
      for (int i = 1; i < DEPTH; i++) begin
        pipe_r[i] <= pipe_r[i-1];
      end
    end
  end

  assign tap_s   = pipe_r[DEPTH-1];
  assign rvalid0 = tap_s.valid & ~tap_s.port;
  assign rvalid1 = tap_s.valid &  tap_s.port;
  assign rdata0  = rvalid0 ? mem_rdata : {DATA_W{1'b0}};
  assign rdata1  = rvalid1 ? mem_rdata : {DATA_W{1'b0}};

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter with locked bursts and in-order read return.
// Define DMEM_ARB_RR_EN for round-robin conflict resolution (fixed priority otherwise).
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              we0,
  input  logic              lock0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [BE_W-1:0]   be0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic              lock1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [BE_W-1:0]   be1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [BE_W-1:0]   mem_be,
  output logic              mem_we,
  output logic              mem_en,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        owner
);

  arb_state_e state_r;
  arb_state_e state_nxt_s;
  logic       pick1_s;
  logic       gnt0_s;
  logic       gnt1_s;
  logic       xfer_s;

`ifdef DMEM_ARB_RR_EN
  logic last_r;

  // Most recently granted port; resets to port 1 so port 0 wins the first conflict.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_r <= 1'b1;
    end else if (xfer_s) begin
      last_r <= gnt1;
    end else begin
      last_r <= last_r;
    end
  end

  assign pick1_s = ~last_r;
`else
  assign pick1_s = 1'b0;
`endif

  // Ownership state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Grant selection and next ownership state.
  always_comb begin
    gnt0_s      = 1'b0;
    gnt1_s      = 1'b0;
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (req0 && req1) begin
          gnt1_s = pick1_s;
          gnt0_s = ~pick1_s;
        end else begin
          gnt0_s = req0;
          gnt1_s = req1;
        end
      end
      OWN0:    gnt0_s = req0;
      OWN1:    gnt1_s = req1;
      default: state_nxt_s = IDLE;
    endcase
    // A dropped lock with no transfer releases ownership; the other port waits a cycle.
    if (gnt0_s) begin
      state_nxt_s = lock0 ? OWN0 : IDLE;
    end else if (gnt1_s) begin
      state_nxt_s = lock1 ? OWN1 : IDLE;
    end else if ((state_r == OWN0 && !lock0) || (state_r == OWN1 && !lock1)) begin
      state_nxt_s = IDLE;
    end else begin
      state_nxt_s = state_nxt_s;
    end
  end

  assign gnt0   = gnt0_s & reset;
  assign gnt1   = gnt1_s & reset;
  assign xfer_s = (req0 & gnt0) | (req1 & gnt1);
  assign mem_en = xfer_s;
  assign owner  = owner_of(state_r);

  // Command mux toward the memory; idle bus is driven to zero.
  always_comb begin
    mem_addr  = {ADDR_W{1'b0}};
    mem_be    = {BE_W{1'b0}};
    mem_we    = 1'b0;
    mem_wdata = {DATA_W{1'b0}};
    if (gnt1) begin
      mem_addr  = addr1;
      mem_be    = be1;
      mem_we    = we1;
      mem_wdata = wdata1;
    end else if (gnt0) begin
      mem_addr  = addr0;
      mem_be    = be0;
      mem_we    = we0;
      mem_wdata = wdata0;
    end else begin
      mem_we    = 1'b0;
    end
  end

  dmem_arbiter_rd_tag_pipe #(
    .DEPTH(RD_LAT)
  ) u_rd_tag_pipe (
    .clk       (clk),
    .reset     (reset),
    .push_valid(xfer_s & ~mem_we),
    .push_port (gnt1),
    .mem_rdata (mem_rdata),
    .rvalid0   (rvalid0),
    .rvalid1   (rvalid1),
    .rdata0    (rdata0),
    .rdata1    (rdata1)
  );

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: directed commands push expected read
// returns; a negedge monitor pops and checks them against rvalid/rdata.
module tb_dmem_arbiter;

  localparam int ADDR_W = 8;
  localparam int RD_LAT = 2;
`ifdef DMEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  typedef struct packed {
    logic        port;
    logic [31:0] data;
    logic [31:0] cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic req0 = 1'b0, we0 = 1'b0, lock0 = 1'b0;
  logic req1 = 1'b0, we1 = 1'b0, lock1 = 1'b0;
  logic [ADDR_W-1:0] addr0 = '0, addr1 = '0;
  logic [3:0]  be0 = 4'hF, be1 = 4'hF;
  logic [31:0] wdata0 = 32'd0, wdata1 = 32'd0;
  logic gnt0, gnt1, rvalid0, rvalid1, mem_we, mem_en;
  logic [31:0] rdata0, rdata1, mem_wdata, mem_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0] mem_be;
  logic [1:0] owner;

  logic [31:0] mem [64];
  logic [31:0] rd_pipe [RD_LAT];
  logic [31:0] cyc = 32'd0;
  exp_t sb [$];
  exp_t mon_e;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .we0(we0), .lock0(lock0), .addr0(addr0), .be0(be0), .wdata0(wdata0),
    .req1(req1), .we1(we1), .lock1(lock1), .addr1(addr1), .be1(be1), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1),
    .mem_addr(mem_addr), .mem_be(mem_be), .mem_we(mem_we), .mem_en(mem_en),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .owner(owner)
  );

  always @(posedge clk) cyc <= cyc + 32'd1;

  // Memory model: preloaded while reset is low; idle read slots return a junk pattern.
  assign mem_rdata = rd_pipe[RD_LAT-1];
  always @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'(i);
      mem[4]  <= 32'hDEADBEEF;
      mem[5]  <= 32'h05050014;
      mem[6]  <= 32'h06060018;
      mem[8]  <= 32'hA0A00020;
      mem[9]  <= 32'hB1B10024;
      mem[16] <= 32'h11223344;
    end else if (mem_en && mem_we) begin
      for (int b = 0; b < 4; b++)
        if (mem_be[b]) mem[mem_addr[7:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
    rd_pipe[0] <= (mem_en && !mem_we) ? mem[mem_addr[7:2]] : 32'hBAD0BAD0;
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every read return, checks zeroed idle rdata.
  always @(negedge clk) begin
    if (!rvalid0) chk("rdata0_zero", rdata0, 32'd0);
    if (!rvalid1) chk("rdata1_zero", rdata1, 32'd0);
    if (rvalid0 || rvalid1) begin
      chk("rv_onehot", {31'd0, rvalid0 & rvalid1}, 32'd0);
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rv_unexpected: got rvalid0=%0b rvalid1=%0b at cycle %0d expected none",
                 rvalid0, rvalid1, cyc);
      end else begin
        mon_e = sb.pop_front();
        chk("rv_port", {31'd0, rvalid1}, {31'd0, mon_e.port});
        chk("rv_data", rvalid1 ? rdata1 : rdata0, mon_e.data);
        chk("rv_cycle", cyc, mon_e.cyc);
      end
    end
  end

  // One command cycle: check grants/owner/bus at negedge, log expected read, clock it.
  task automatic step(input logic eg0, input logic eg1, input logic [1:0] eown,
                      input logic [31:0] erd, input string tag);
    exp_t e;
    @(negedge clk);
    chk({tag, "_gnt0"}, {31'd0, gnt0}, {31'd0, eg0});
    chk({tag, "_gnt1"}, {31'd0, gnt1}, {31'd0, eg1});
    chk({tag, "_owner"}, {30'd0, owner}, {30'd0, eown});
    chk({tag, "_mem_en"}, {31'd0, mem_en}, {31'd0, (eg0 & req0) | (eg1 & req1)});
    if (eg0 || eg1) begin
      chk({tag, "_mem_addr"}, 32'(mem_addr), 32'(eg1 ? addr1 : addr0));
      chk({tag, "_mem_we"}, {31'd0, mem_we}, {31'd0, eg1 ? we1 : we0});
      chk({tag, "_mem_be"}, {28'd0, mem_be}, {28'd0, eg1 ? be1 : be0});
      if (eg1 ? we1 : we0) begin
        chk({tag, "_mem_wdata"}, mem_wdata, eg1 ? wdata1 : wdata0);
      end else begin
        e.port = eg1;
        e.data = erd;
        e.cyc  = cyc + 32'(RD_LAT);
        sb.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_gnt", {30'd0, gnt1, gnt0}, 32'd0);
    chk("rst_mem", {30'd0, mem_en, mem_we}, 32'd0);
    chk("rst_rvalid", {30'd0, rvalid1, rvalid0}, 32'd0);
    chk("rst_owner", {30'd0, owner}, 32'd0);
    reset = 1'b1;

    // Conflict in IDLE, held four cycles, locks low.
    req0 = 1'b1; addr0 = 8'h20; req1 = 1'b1; addr1 = 8'h24;
    for (int i = 0; i < 4; i++) begin
      logic g1;
      g1 = RR & i[0];
      step(~g1, g1, 2'd0, g1 ? 32'hB1B10024 : 32'hA0A00020, "conf");
    end
    req0 = 1'b0; req1 = 1'b0;
    repeat (3) step(1'b0, 1'b0, 2'd0, 32'd0, "idle");

    // Single read from port 0.
    req0 = 1'b1; addr0 = 8'h10;
    step(1'b1, 1'b0, 2'd0, 32'hDEADBEEF, "rd0");
    req0 = 1'b0;
    repeat (3) step(1'b0, 1'b0, 2'd0, 32'd0, "idle");

    // Locked write burst on port 1 while port 0 waits.
    req1 = 1'b1; we1 = 1'b1; lock1 = 1'b1; be1 = 4'hF; addr1 = 8'h30; wdata1 = 32'h30300001;
    step(1'b0, 1'b1, 2'd0, 32'd0, "lk_w1");
    req0 = 1'b1; we0 = 1'b0; lock0 = 1'b0; addr0 = 8'h34;
    addr1 = 8'h34; wdata1 = 32'h34340002;
    step(1'b0, 1'b1, 2'd2, 32'd0, "lk_w2");
    addr1 = 8'h38; wdata1 = 32'h38380003;
    step(1'b0, 1'b1, 2'd2, 32'd0, "lk_w3");
    req1 = 1'b0; lock1 = 1'b0; we1 = 1'b0;
    step(1'b0, 1'b0, 2'd2, 32'd0, "lk_rel");
    step(1'b1, 1'b0, 2'd0, 32'h34340002, "lk_p0");
    req0 = 1'b0;
    repeat (3) step(1'b0, 1'b0, 2'd0, 32'd0, "idle");

    // Back-to-back reads 0, 1, 0.
    req0 = 1'b1; addr0 = 8'h14;
    step(1'b1, 1'b0, 2'd0, 32'h05050014, "b2b_a");
    req0 = 1'b0; req1 = 1'b1; addr1 = 8'h18;
    step(1'b0, 1'b1, 2'd0, 32'h06060018, "b2b_b");
    req1 = 1'b0; req0 = 1'b1; addr0 = 8'h10;
    step(1'b1, 1'b0, 2'd0, 32'hDEADBEEF, "b2b_c");
    req0 = 1'b0;
    repeat (4) step(1'b0, 1'b0, 2'd0, 32'd0, "idle");

    // Partial-byte write, then read back the merged word.
    req0 = 1'b1; we0 = 1'b1; be0 = 4'b0100; addr0 = 8'h40; wdata0 = 32'h00AB0000;
    step(1'b1, 1'b0, 2'd0, 32'd0, "wr");
    req0 = 1'b0; we0 = 1'b0; be0 = 4'hF;
    repeat (3) step(1'b0, 1'b0, 2'd0, 32'd0, "idle");
    req0 = 1'b1;
    step(1'b1, 1'b0, 2'd0, 32'h11AB3344, "wr_rb");
    req0 = 1'b0;
    repeat (3) step(1'b0, 1'b0, 2'd0, 32'd0, "idle");

    // Reset during an OWN1 burst with a read in flight.
    req1 = 1'b1; lock1 = 1'b1; addr1 = 8'h24;
    step(1'b0, 1'b1, 2'd0, 32'hB1B10024, "pre_rst");
    reset = 1'b0; req0 = 1'b1; addr0 = 8'h10;
    sb.delete();
    #1;
    chk("mid_rst_gnt", {30'd0, gnt1, gnt0}, 32'd0);
    chk("mid_rst_mem", {30'd0, mem_en, mem_we}, 32'd0);
    chk("mid_rst_rvalid", {30'd0, rvalid1, rvalid0}, 32'd0);
    chk("mid_rst_owner", {30'd0, owner}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1; req0 = 1'b0; req1 = 1'b0; lock1 = 1'b0;
    step(1'b0, 1'b0, 2'd0, 32'd0, "post_rst_idle");
    req0 = 1'b1;
    step(1'b1, 1'b0, 2'd0, 32'hDEADBEEF, "post_rst_rd");
    req0 = 1'b0;
    repeat (6) step(1'b0, 1'b0, 2'd0, 32'd0, "drain");
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
